// File: rtl/menu_key_pkg.sv
// ---------------------------------------------------------------------------
// menu_key_pkg
// Shared definitions for the menu key conditioner:
//   - key index constants (bit positions in key_n and in the event vectors)
//   - repeat-FSM state encoding
//   - fixed-priority arbiter helper (right > left > up > down)
// ---------------------------------------------------------------------------
package menu_key_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int N_KEYS    = 4;

  // Only up and down auto-repeat; they occupy key indices 0 and 1.
  localparam int RPT_KEYS  = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Returns a one-hot (or all-zero) grant: only the highest-priority event
  // survives, the rest are dropped.
  function automatic logic [N_KEYS-1:0] arbitrate(input logic [N_KEYS-1:0] ev);
    logic [N_KEYS-1:0] grant;
    grant = {N_KEYS{1'b0}};
    if (ev[KEY_RIGHT]) begin
      grant[KEY_RIGHT] = 1'b1;
    end else if (ev[KEY_LEFT]) begin
      grant[KEY_LEFT] = 1'b1;
    end else if (ev[KEY_UP]) begin
      grant[KEY_UP] = 1'b1;
    end else if (ev[KEY_DOWN]) begin
      grant[KEY_DOWN] = 1'b1;
    end else begin
      grant = {N_KEYS{1'b0}};
    end
    return grant;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push-button channel: 2-flop synchroniser (inverted to active-high
// "pressed"), stability counter, and press-edge detector.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   key_raw_n  - raw active-low button, asynchronous to clk
//   level      - debounced level, 1 = pressed (registered)
//   press      - one-cycle pulse on the debounced rising edge (registered)
// The debounced level toggles on the DEBOUNCE_CYCLES-th consecutive
// synchronised sample that disagrees with it; any agreeing sample restarts
// the count, so shorter glitches never reach the output.
// ---------------------------------------------------------------------------
module key_debounce
  import menu_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser; the inversion makes 1 mean "pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ~key_raw_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, debounced level and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r >= CNT_LAST) begin
        // This sample is the DEBOUNCE_CYCLES-th disagreeing one.
        cnt_r   <= {CW{1'b0}};
        level_r <= sync2_r;
        press_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/menu_key_conditioner.sv
// ---------------------------------------------------------------------------
// menu_key_conditioner
// Turns four raw active-low push-buttons into clean one-cycle strobes for the
// menu state machine.
// Ports:
//   sys_clk       - sole clock
//   sys_rst_n     - asynchronous active-low reset
//   key_n[3:0]    - raw buttons, active-low: 0 up, 1 down, 2 left, 3 right
//   button_up     - navigation strobe (press + auto-repeat)
//   button_down   - navigation strobe (press + auto-repeat)
//   button_left   - navigation strobe
//   button_right  - navigation / confirm strobe
//   game_exit     - strobe after left has been held LONG_PRESS cycles
// At most one navigation strobe fires per cycle (right > left > up > down);
// losing events are discarded. game_exit is outside the arbitration.
// All outputs are registered and clear asynchronously on reset.
// ---------------------------------------------------------------------------
module menu_key_conditioner
  import menu_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned LONG_PRESS      = 75_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_n,
  output logic       button_up,
  output logic       button_down,
  output logic       button_left,
  output logic       button_right,
  output logic       game_exit
);

  // Repeat counter is shared by DELAY and REPEAT, so it is sized for the
  // larger of the two intervals.
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);

  localparam int unsigned LW = $clog2(LONG_PRESS + 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS - 1);
  localparam logic [LW-1:0] LP_SAT  = LW'(LONG_PRESS);
  localparam logic [LW-1:0] LP_ONE  = LW'(1);

  logic [N_KEYS-1:0]   level_s;
  logic [N_KEYS-1:0]   press_s;

  rpt_state_e          rpt_state_r [RPT_KEYS];
  logic [RW-1:0]       rpt_cnt_r   [RPT_KEYS];
  logic [RPT_KEYS-1:0] rpt_ev_s;

  logic                lp_active_r;
  logic [LW-1:0]       lp_cnt_r;
  logic                exit_ev_s;

  logic [N_KEYS-1:0]   nav_ev_s;
  logic [N_KEYS-1:0]   grant_s;

  // ------------------------------------------------------------------------
  // Per-key synchronise + debounce + press detect
  // ------------------------------------------------------------------------
  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .key_raw_n(key_n[g]),
      .level    (level_s[g]),
      .press    (press_s[g])
    );
  end

  // Up/down repeat FSMs; a debounced release returns a lane to IDLE from any state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < RPT_KEYS; i++) begin
        rpt_state_r[i] <= RPT_IDLE;
        rpt_cnt_r[i]   <= {RW{1'b0}};
      end
    end else begin
      for (int i = 0; i < RPT_KEYS; i++) begin
        if (!level_s[i]) begin
          rpt_state_r[i] <= RPT_IDLE;
          rpt_cnt_r[i]   <= {RW{1'b0}};
        end else begin
          case (rpt_state_r[i])
            RPT_IDLE: begin
              rpt_cnt_r[i] <= {RW{1'b0}};
              if (press_s[i]) begin
                rpt_state_r[i] <= RPT_DELAY;
              end else begin
                rpt_state_r[i] <= RPT_IDLE;
              end
            end
            RPT_DELAY: begin
              if (rpt_cnt_r[i] >= DLY_LAST) begin
                rpt_state_r[i] <= RPT_REPEAT;
                rpt_cnt_r[i]   <= {RW{1'b0}};
              end else begin
                rpt_cnt_r[i]   <= rpt_cnt_r[i] + RPT_ONE;
              end
            end
            RPT_REPEAT: begin
              if (rpt_cnt_r[i] >= PER_LAST) begin
                rpt_cnt_r[i] <= {RW{1'b0}};
              end else begin
                rpt_cnt_r[i] <= rpt_cnt_r[i] + RPT_ONE;
              end
            end
            default: begin
              rpt_state_r[i] <= RPT_IDLE;
              rpt_cnt_r[i]   <= {RW{1'b0}};
            end
          endcase
        end
      end
    end
  end

  // Repeat events: the last count of DELAY or of each REPEAT period. Gating
  // by level kills any event once the debounced release has landed.
  always_comb begin
    rpt_ev_s = {RPT_KEYS{1'b0}};
    for (int i = 0; i < RPT_KEYS; i++) begin
      if (level_s[i] &&
          (((rpt_state_r[i] == RPT_DELAY)  && (rpt_cnt_r[i] >= DLY_LAST)) ||
           ((rpt_state_r[i] == RPT_REPEAT) && (rpt_cnt_r[i] >= PER_LAST)))) begin
        rpt_ev_s[i] = 1'b1;
      end else begin
        rpt_ev_s[i] = 1'b0;
      end
    end
  end

  // Long-press counter for left; it parks at LONG_PRESS so the exit fires once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lp_active_r <= 1'b0;
      lp_cnt_r    <= {LW{1'b0}};
    end else if (!level_s[KEY_LEFT]) begin
      lp_active_r <= 1'b0;
      lp_cnt_r    <= {LW{1'b0}};
    end else if (press_s[KEY_LEFT]) begin
      lp_active_r <= 1'b1;
      lp_cnt_r    <= {LW{1'b0}};
    end else if (lp_active_r && (lp_cnt_r < LP_SAT)) begin
      lp_cnt_r    <= lp_cnt_r + LP_ONE;
    end else begin
      lp_cnt_r    <= lp_cnt_r;
    end
  end

  assign exit_ev_s = lp_active_r && level_s[KEY_LEFT] && (lp_cnt_r == LP_LAST);

  // Collect navigation events and pick the single winner.
  always_comb begin
    nav_ev_s            = {N_KEYS{1'b0}};
    nav_ev_s[KEY_RIGHT] = press_s[KEY_RIGHT];
    nav_ev_s[KEY_LEFT]  = press_s[KEY_LEFT];
    nav_ev_s[KEY_UP]    = press_s[KEY_UP]   | rpt_ev_s[KEY_UP];
    nav_ev_s[KEY_DOWN]  = press_s[KEY_DOWN] | rpt_ev_s[KEY_DOWN];
    grant_s             = arbitrate(nav_ev_s);
  end

  // Output strobe registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      button_up    <= 1'b0;
      button_down  <= 1'b0;
      button_left  <= 1'b0;
      button_right <= 1'b0;
      game_exit    <= 1'b0;
    end else begin
      button_up    <= grant_s[KEY_UP];
      button_down  <= grant_s[KEY_DOWN];
      button_left  <= grant_s[KEY_LEFT];
      button_right <= grant_s[KEY_RIGHT];
      game_exit    <= exit_ev_s;
    end
  end

endmodule

// File: tb/tb_menu_key_conditioner.sv
// ---------------------------------------------------------------------------
// Testbench for menu_key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5, LONG_PRESS=20.
// Cycle index i=0 is the first rising edge that samples the new key level;
// a press strobe is then high in the cycle after edge 6, repeats follow at
// 16, 21, 26, ... and game_exit at 26. Outputs are sampled on the falling
// edge. Observed vector bits: [0] up, [1] down, [2] left, [3] right, [4] exit.
// ---------------------------------------------------------------------------
module tb_menu_key_conditioner;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] key_n;
  logic       button_up;
  logic       button_down;
  logic       button_left;
  logic       button_right;
  logic       game_exit;

  logic [4:0] obs;
  int         errors = 0;
  int         checks = 0;

  menu_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .LONG_PRESS     (20)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_n       (key_n),
    .button_up   (button_up),
    .button_down (button_down),
    .button_left (button_left),
    .button_right(button_right),
    .game_exit   (game_exit)
  );

  always #5 sys_clk = ~sys_clk;

  assign obs = {game_exit, button_right, button_left, button_down, button_up};

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key_n     = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, 5'b00000);
      end
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp_v;
    key_n[3] = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6) ? 5'b01000 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 9) key_n[3] = 1'b1;
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp_v;
    // Four 3-cycle low pulses separated by 1-cycle gaps: all rejected.
    for (int j = 0; j < 20; j++) begin
      key_n[0] = ((j % 4) != 3 && j < 16) ? 1'b0 : 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL bounce_reject cycle %0d: got %b expected %b", j, obs, 5'b00000);
      end
    end
    // A proper hold then gives exactly one up strobe.
    key_n[0] = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_hold cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 8) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_auto_repeat();
    logic [4:0] exp_v;
    key_n[1] = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6 || i == 16 || i == 21 || i == 26 || i == 31 || i == 36) ?
              5'b00010 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL auto_repeat cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      // Sampled high at edge 33; debounced release lands at edge 38.
      if (i == 32) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_long_press();
    logic [4:0] exp_v;
    key_n[2] = 1'b0;
    for (int i = 0; i <= 45; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6) ? 5'b00100 : ((i == 26) ? 5'b10000 : 5'b00000);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_press cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 30) key_n[2] = 1'b1;
    end
    // Short press afterwards: left strobe only, the counter was cleared.
    key_n[2] = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6) ? 5'b00100 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_left cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 8) key_n[2] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp_v;
    key_n = 4'b0110;
    for (int i = 0; i <= 35; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == 6)                 exp_v = 5'b01000;
      else if (i == 16 || i == 21) exp_v = 5'b00001;
      else                        exp_v = 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 8)  key_n[3] = 1'b1;
      if (i == 17) key_n[0] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] exp_v;
    key_n[0] = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6 || i == 16) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pre_reset_repeat cycle %0d: got %b expected %b", i, obs, exp_v);
      end
    end
    // button_up is high right now; reset must clear it without a clock edge.
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async_clear: got %b expected %b", obs, 5'b00000);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_mid_hold cycle %0d: got %b expected %b", i, obs, 5'b00000);
      end
    end
    sys_rst_n = 1'b1;
    // Key still held: fresh press after the normal latency.
    for (int i = 0; i <= 20; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_v = (i == 6) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset_press cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 8) key_n[0] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/menu_key_conditioner.md
# menu_key_conditioner

Front end that turns the four raw board push-buttons into the clean single-cycle `button_up/down/left/right` and `game_exit` strobes consumed by the menu state machine. It sits between the board pins and the menu FSM. Per key, it synchronises and debounces the input, then detects presses. It arbitrates so that at most one navigation strobe fires per cycle, auto-repeats up/down while held, and raises `game_exit` on a long press of left.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples before a debounced level changes (20 ms at 50 MHz).
- `REPEAT_DELAY`, default 25_000_000: cycles a held up/down key waits, after its press strobe, before the first repeat.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeat strobes.
- `LONG_PRESS`, default 75_000_000: cycles left must stay held, after its press strobe, to emit `game_exit`.
- `sys_clk`, in, 1: sole clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `key_n`, in, 4: raw buttons, active-low, asynchronous to `sys_clk`. Index 0 = up, 1 = down, 2 = left, 3 = right.
- `button_up`, out, 1: one-cycle navigation strobe.
- `button_down`, out, 1: one-cycle navigation strobe.
- `button_left`, out, 1: one-cycle navigation strobe.
- `button_right`, out, 1: one-cycle strobe; also used as the confirm action.
- `game_exit`, out, 1: one-cycle strobe on a long press of left.

## Operation
- Reset: all outputs 0. Synchroniser and debounced levels reset to released. All counters reset to 0. Repeat FSMs reset to IDLE.
- Synchroniser: 2 flops per key, inverted to an active-high `pressed`.
- Debounce: a per-key counter runs while the synchronised level differs from the debounced level. It clears on any sample equal to the debounced level. When it reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears. Glitches shorter than `DEBOUNCE_CYCLES` are fully rejected.
- Press event: a rising edge of the debounced level. A release produces no event.
- Repeat FSM (up and down only):
  - IDLE → DELAY on a press event.
  - DELAY → REPEAT after `REPEAT_DELAY` cycles, issuing a repeat event.
  - REPEAT issues a further event every `REPEAT_PERIOD` cycles.
  - Any state → IDLE on debounced release.
- Long press (left): a counter starts on the left press event. At `LONG_PRESS` cycles it emits one `game_exit` strobe and saturates, so no further strobes occur until release. Release clears it.
- Arbitration: event priority right > left > up > down. Only the highest-priority event is output in a given cycle. Losing events are dropped, not queued.
- `game_exit` bypasses arbitration and may coincide with a navigation strobe.
- A key held through reset deassertion is seen as a fresh press. It strobes once after the normal latency.
- Counter widths: `$clog2(param+1)` each, with no wrap-around. Every counter stops at its terminal value.

## Timing
- All outputs are registered.
- Press latency: `key_n` goes low and stays low. Let E be the first `sys_clk` edge that samples it low. The strobe is high for exactly the cycle following edge E + `DEBOUNCE_CYCLES` + 2.
- Repeat strobes: first at press strobe + `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
- `game_exit`: press strobe + `LONG_PRESS` cycles.
- Release is recognised `DEBOUNCE_CYCLES` + 2 cycles after `key_n` goes high. No repeat or exit strobe may occur after that point.
- An asynchronous reset mid-debounce or mid-repeat clears everything immediately. Outputs drop within the same cycle, with no pulse stretching.

## Structure
- Package `menu_key_pkg`:
  - key index constants `KEY_UP`=0, `KEY_DOWN`=1, `KEY_LEFT`=2, `KEY_RIGHT`=3, `N_KEYS`=4;
  - repeat-FSM state encoding IDLE/DELAY/REPEAT.
- Sub-module `key_debounce`, instantiated 4×. It holds the synchroniser, debounce counter and edge detector. Outputs: debounced level and press pulse.
- The top level holds the two repeat FSMs, the long-press counter and the priority arbiter.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, `LONG_PRESS`=20.
- Clean press: `key_n[3]` goes low at edge 0 and is held 3 cycles past the strobe, then released. → `button_right` high only in the cycle after edge 6; no other output toggles.
- Bounce rejection: `key_n[0]` pulses low for 3 cycles, 4 times with 1-cycle gaps, then released. → no strobe. A subsequent hold of 5 or more cycles gives exactly one `button_up`.
- Auto-repeat: hold `key_n[1]` for 30 cycles after its strobe. → `button_down` at strobe, +10, +15, +20, +25, +30. Release gives no further strobes.
- Long press: hold `key_n[2]` for 25 cycles after the strobe. → one `button_left`, then one `game_exit` at strobe +20, then nothing until release and a new press.
- Simultaneous press: `key_n[3]` and `key_n[0]` fall on the same edge. → only `button_right` fires. Up's press strobe is dropped; its repeats follow at +10 and +15.
- Reset mid-hold: assert `sys_rst_n`=0 during up auto-repeat while keeping the key held. → outputs go 0 immediately. After release of reset, one fresh `button_up` arrives after the normal latency.
